serial_divider: RTL

//  - Unsigned restoring shift-subtract divider; the inverse of serial_multiplier.
//  - Produces one quotient bit per clk, MSB first, with a start/busy/done handshake.
//  - Sits in the arithmetic unit next to serial_multiplier; the benches cross-check the two.

---
 rtl/serial_divider.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/serial_divider.sv
`timescale 1ns/1ps
// serial_divider: unsigned restoring shift-subtract divider, one quotient bit
// per clock, MSB first, with a start/busy/done handshake.
// Optional feature macro: SERIAL_DIVIDER_DBZ_EN adds the dbz port and a
// one-cycle divide-by-zero short cut (q = all ones, r = a, RUN skipped).
module serial_divider #(
    parameter int WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
    output logic [WIDTH-1:0]         q,
    output logic [WIDTH-1:0]         r,
    output logic                     busy,
    output logic                     done,
`ifdef SERIAL_DIVIDER_DBZ_EN
    output logic                     dbz,
`endif
    output logic [$clog2(WIDTH):0]   i
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_reg,    state_next;
    logic [WIDTH-1:0]   dividend_reg, dividend_next;
    logic [WIDTH-1:0]   divisor_reg,  divisor_next;
    // The partial remainder is always below the divisor after a restoring
    // step, so WIDTH bits hold it; only the trial value needs the extra bit.
    logic [WIDTH-1:0]   rem_reg,      rem_next;
    logic [WIDTH-1:0]   qs_reg,       qs_next;
    logic [WIDTH-1:0]   q_reg,        q_next;
    logic [WIDTH-1:0]   r_reg,        r_next;
    logic [CNT_W-1:0]   i_reg,        i_next;
    logic               dbz_reg,      dbz_next;

    logic [WIDTH:0]     trial;
    logic               q_bit;

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            dividend_reg <= '0;
            divisor_reg  <= '0;
            rem_reg      <= '0;
            qs_reg       <= '0;
            q_reg        <= '0;
            r_reg        <= '0;
            i_reg        <= '0;
            dbz_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            dividend_reg <= dividend_next;
            divisor_reg  <= divisor_next;
            rem_reg      <= rem_next;
            qs_reg       <= qs_next;
            q_reg        <= q_next;
            r_reg        <= r_next;
            i_reg        <= i_next;
            dbz_reg      <= dbz_next;
        end
    end

    // Next-state and datapath logic: accept in IDLE, one restoring step per RUN cycle.
    always_comb begin
        state_next    = state_reg;
        dividend_next = dividend_reg;
        divisor_next  = divisor_reg;
        rem_next      = rem_reg;
        qs_next       = qs_reg;
        q_next        = q_reg;
        r_next        = r_reg;
        i_next        = i_reg;
        dbz_next      = dbz_reg;
        trial         = '0;
        q_bit         = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    dividend_next = a;
                    divisor_next  = b;
                    rem_next      = '0;
                    qs_next       = '0;
                    i_next        = '0;
                    dbz_next      = 1'b0;
                    state_next    = RUN;
`ifdef SERIAL_DIVIDER_DBZ_EN
                    if (b == '0) begin
                        q_next     = '1;
                        r_next     = a;
                        dbz_next   = 1'b1;
                        state_next = DONE;
                    end
`endif
                end
            end
            RUN: begin
                trial         = {rem_reg, dividend_reg[WIDTH-1]};
                dividend_next = dividend_reg << 1;
                if (trial >= {1'b0, divisor_reg}) begin
                    rem_next = WIDTH'(trial - {1'b0, divisor_reg});
                    q_bit    = 1'b1;
                end else begin
                    rem_next = trial[WIDTH-1:0];
                end
                qs_next = {qs_reg[WIDTH-2:0], q_bit};
                if (i_reg == CNT_W'(WIDTH - 1)) begin
                    q_next     = qs_next;
                    r_next     = rem_next;
                    i_next     = '0;
                    state_next = DONE;
                end else begin
                    i_next = i_reg + CNT_W'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign q    = q_reg;
    assign r    = r_reg;
    assign i    = i_reg;
    assign busy = (state_reg == RUN);
    assign done = (state_reg == DONE);
`ifdef SERIAL_DIVIDER_DBZ_EN
    assign dbz  = dbz_reg;
`else
    // Without the divide-by-zero short cut the flag register never leaves 0.
    logic unused_dbz;
    assign unused_dbz = dbz_reg;
`endif

endmodule
